branch_resolve: RTL and testbench
=================================

# branch_resolve

Branch resolution unit for the pipelined CPU. It takes a decoded conditional branch from the ID stage together with its register operands, evaluates the condition with signed comparisons (equal, less-than-zero, zero), and computes the target address. When the branch is taken, it issues a one-cycle redirect with a flush of IF/ID. It sits between the ID-stage decoder/forwarding logic and the PC-select mux, downstream of the ALU compare flags' producer.

## Interface
Parameters:
- `XLEN`, default 32: operand and PC width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `br_valid`, in, 1: ID presents a branch this cycle.
- `br_ready`, out, 1: unit can accept a branch (state IDLE).
- `br_op`, in, 3: branch opcode (`br_pkg` encoding).
- `rs_val`, in, XLEN: forwarded rs operand.
- `rt_val`, in, XLEN: forwarded rt operand.
- `opnd_ready`, in, 1: forwarded operands are valid (no load-use hazard pending).
- `pc_plus4`, in, XLEN: address of the branch plus 4.
- `imm16`, in, 16: branch offset in words.
- `flush_in`, in, 1: higher-priority flush (exception/eret); aborts any in-flight branch.
- `stall_id`, out, 1: hold IF/ID.
- `redirect`, out, 1: one-cycle pulse; PC loads `redirect_pc`.
- `redirect_pc`, out, XLEN: branch target.
- `flush_ifid`, out, 1: asserted together with `redirect`.
- `taken`, out, 1: registered outcome of the last resolved branch.
- `stat_total`, out, 32: statistics, resolved-branch count (see Configuration).
- `stat_taken`, out, 32: statistics, taken-branch count (see Configuration).

## Operation
- The unit has three states: IDLE, EVAL, REDIR.
- Accept condition: `br_valid & br_ready & opnd_ready & ~flush_in`. On accept, register `br_op`, `rs_val`, `rt_val`, and the target, then move to EVAL.
- `stall_id = br_valid & ~(accept)`. This is combinational and covers both operand-not-ready and busy.
- Target computation: `pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00})`, modulo 2^32. Wrap-around is silent.
- Condition evaluation, all signed two's complement:
  - BEQ=0: rs==rt.
  - BNE=1: rs!=rt.
  - BGEZ=2: !rs[31].
  - BGTZ=3: !rs[31] & rs!=0.
  - BLEZ=4: rs[31] | rs==0.
  - BLTZ=5: rs[31].
  - Encodings 6 and 7 resolve as not taken.
- EVAL: latch `taken`. If taken, go to REDIR; otherwise go to IDLE with no redirect.
- REDIR: `redirect=1`, `flush_ifid=1`, `redirect_pc` = registered target. Return to IDLE next cycle.
- `flush_in` in any state returns the unit to IDLE next cycle, suppresses any pending redirect, and leaves `taken` unchanged. If `flush_in` arrives during REDIR, the pulse is still visible that cycle; the PC mux gives `flush_in` priority.
- Reset values: state IDLE, `redirect`=0, `flush_ifid`=0, `redirect_pc`=0, `taken`=0, `stat_*`=0. `br_ready`=1 and `stall_id`=`br_valid` (combinational).
- Reset mid-operation discards the branch and produces no redirect.

## Timing
- Accept happens in cycle N.
- In cycle N+1 (EVAL), `br_ready`=0.
- In cycle N+2, if taken: `redirect`/`flush_ifid` high for exactly one cycle. If not taken: `br_ready`=1.
- Back-to-back branches: the earliest next accept is N+2 for a not-taken branch and N+3 for a taken one.
- `redirect_pc` is registered and stable while `redirect`=1.
- `taken` updates at the end of N+1.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `stat_total` increments on each EVAL that flush does not abort.
  - `stat_taken` increments when that evaluation is taken.
  - Both counters are 32-bit and saturate at 0xFFFFFFFF.
- `BRANCH_STATS_EN` undefined: no counter flops; both ports are tied to 0.

## Structure
- `br_pkg` holds:
  - the `br_op_t` 3-bit encoding constants BR_BEQ..BR_BLTZ;
  - the state encoding for IDLE/EVAL/REDIR;
  - `XLEN_DEF`=32.
- Sub-module `branch_cmp` (combinational):
  - inputs: rs, rt, op;
  - outputs: `eq`, `rs_neg`, `rs_zero`, `cond`.

## Test plan
- BEQ, rs=rt=0x12345678, pc_plus4=0x00400004, imm16=0x0003 -> N+2: `redirect`=1 for one cycle, `redirect_pc`=0x00400010, `flush_ifid`=1, `taken`=1.
- BLTZ, rs=0x00000001 -> no redirect, `taken`=0, `br_ready`=1 at N+2. BGTZ, rs=0x80000000 -> not taken. BLEZ, rs=0 -> taken.
- Negative offset: imm16=0xFFFF, pc_plus4=0x00000000 -> `redirect_pc`=0xFFFFFFFC (wrap).
- `opnd_ready`=0 for 2 cycles with `br_valid`=1 -> `stall_id`=1 for both cycles, accept on the third, redirect two cycles later.
- Taken BNE, `flush_in`=1 in EVAL -> IDLE next cycle, no `redirect`; `stat_total` unchanged with `BRANCH_STATS_EN` defined.
- Deassert `rst_n` during REDIR -> `redirect`=0 immediately (asynchronous), state IDLE, counters 0.

Source files
------------

// File: rtl/br_pkg.sv
// br_pkg: branch opcode encoding, resolve FSM states and default width.
package br_pkg;
    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BGEZ = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLEZ = 3'd4,
        BR_BLTZ = 3'd5
    } br_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_REDIR = 2'd2
    } state_t;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: signed branch condition evaluation from rs/rt and opcode.
module branch_cmp
    import br_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic [2:0]      op,
    output logic            eq,
    output logic            rs_neg,
    output logic            rs_zero,
    output logic            cond
);
    assign eq      = rs == rt;
    assign rs_neg  = rs[XLEN-1];
    assign rs_zero = rs == '0;

    // Unassigned opcodes 6 and 7 fall through to not taken.
    always_comb
        cond = (op == BR_BEQ)  ? eq :
               (op == BR_BNE)  ? !eq :
               (op == BR_BGEZ) ? !rs_neg :
               (op == BR_BGTZ) ? (!rs_neg && !rs_zero) :
               (op == BR_BLEZ) ? (rs_neg || rs_zero) :
               (op == BR_BLTZ) ? rs_neg : 1'b0;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch resolution FSM with one-cycle PC redirect.
// Optional resolve/taken counters are built when BRANCH_STATS_EN is defined.
module branch_resolve
    import br_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            opnd_ready,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [15:0]     imm16,
    input  logic            flush_in,
    output logic            stall_id,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_ifid,
    output logic            taken,
    output logic [31:0]     stat_total,
    output logic [31:0]     stat_taken
);
    state_t          state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] rs_q, rt_q, tgt_q;
    logic            accept, cond;

    assign br_ready    = state == S_IDLE;
    assign accept      = br_valid && br_ready && opnd_ready && !flush_in;
    assign stall_id    = br_valid && !accept;
    assign redirect_pc = tgt_q;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs      (rs_q),
        .rt      (rt_q),
        .op      (op_q),
        .eq      (),
        .rs_neg  (),
        .rs_zero (),
        .cond    (cond)
    );

    // tgt_q only loads on accept, so it stays stable through REDIR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            tgt_q      <= '0;
            taken      <= 1'b0;
            redirect   <= 1'b0;
            flush_ifid <= 1'b0;
        end else begin
            redirect   <= 1'b0;
            flush_ifid <= 1'b0;
            if (flush_in) begin
                state <= S_IDLE;
            end else if (state == S_IDLE) begin
                if (accept) begin
                    state <= S_EVAL;
                    op_q  <= br_op;
                    rs_q  <= rs_val;
                    rt_q  <= rt_val;
                    tgt_q <= pc_plus4 + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
                end
            end else if (state == S_EVAL) begin
                taken      <= cond;
                redirect   <= cond;
                flush_ifid <= cond;
                state      <= cond ? S_REDIR : S_IDLE;
            end else begin
                state <= S_IDLE;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= '0;
            stat_taken <= '0;
        end else if (state == S_EVAL && !flush_in) begin
            if (stat_total != '1) stat_total <= stat_total + 32'd1;
            if (cond && stat_taken != '1) stat_taken <= stat_taken + 32'd1;
        end
    end
`else
    assign stat_total = '0;
    assign stat_taken = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: randomized and directed checks of branch_resolve against a behavioural model.
module tb_branch_resolve;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        br_valid = 1'b0, opnd_ready = 1'b0, flush_in = 1'b0;
    logic [2:0]  br_op = '0;
    logic [31:0] rs_val = '0, rt_val = '0, pc_plus4 = '0;
    logic [15:0] imm16 = '0;
    logic        br_ready, stall_id, redirect, flush_ifid, taken;
    logic [31:0] redirect_pc, stat_total, stat_taken;

    int          n_checks = 0, n_fail = 0;
    int unsigned m_total = 0, m_taken = 0;
    bit          m_last = 1'b0;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    branch_resolve #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_op(br_op), .rs_val(rs_val), .rt_val(rt_val), .opnd_ready(opnd_ready),
        .pc_plus4(pc_plus4), .imm16(imm16), .flush_in(flush_in), .stall_id(stall_id),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush_ifid(flush_ifid),
        .taken(taken), .stat_total(stat_total), .stat_taken(stat_taken)
    );

    always #5 clk = ~clk;

    function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int a, b;
        a = $signed(rs);
        b = $signed(rt);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return a >= 0;
            3'd3: return a > 0;
            3'd4: return a <= 0;
            3'd5: return a < 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
        int off;
        off = $signed(imm);
        return pc + 32'(off * 4);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents one branch from IDLE, keeps br_valid high throughout, and follows it back to IDLE.
    task automatic run_branch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] pc, input logic [15:0] imm);
        bit exp;
        logic [31:0] tgt;
        exp = ref_taken(op, rs, rt);
        tgt = ref_target(pc, imm);
        br_valid = 1'b1; opnd_ready = 1'b1; br_op = op;
        rs_val = rs; rt_val = rt; pc_plus4 = pc; imm16 = imm;
        #1;
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL accept_stall: got %b want 0", stall_id); end
        step;
        n_checks++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL eval_ready: got %b want 0", br_ready); end
        n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL eval_stall: got %b want 1", stall_id); end
        step;
        n_checks++; if (redirect !== exp) begin n_fail++; $display("FAIL redirect op=%0d rs=%h rt=%h: got %b want %b", op, rs, rt, redirect, exp); end
        n_checks++; if (flush_ifid !== exp) begin n_fail++; $display("FAIL flush_ifid: got %b want %b", flush_ifid, exp); end
        n_checks++; if (taken !== exp) begin n_fail++; $display("FAIL taken op=%0d rs=%h rt=%h: got %b want %b", op, rs, rt, taken, exp); end
        n_checks++; if (br_ready !== !exp) begin n_fail++; $display("FAIL n2_ready: got %b want %b", br_ready, !exp); end
        m_last = exp;
        if (STATS) begin
            m_total++;
            m_taken += exp;
        end
        n_checks++; if (stat_total !== m_total) begin n_fail++; $display("FAIL stat_total: got %0d want %0d", stat_total, m_total); end
        n_checks++; if (stat_taken !== m_taken) begin n_fail++; $display("FAIL stat_taken: got %0d want %0d", stat_taken, m_taken); end
        if (exp) begin
            n_checks++; if (redirect_pc !== tgt) begin n_fail++; $display("FAIL redirect_pc: got %h want %h", redirect_pc, tgt); end
            n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL redir_stall: got %b want 1", stall_id); end
            step;
            n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL pulse_len: got %b want 0", redirect); end
            n_checks++; if (redirect_pc !== tgt) begin n_fail++; $display("FAIL pc_hold: got %h want %h", redirect_pc, tgt); end
            n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL n3_ready: got %b want 1", br_ready); end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; br_valid = 1'b0; opnd_ready = 1'b0;
        #3;
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %b want 0", redirect); end
        n_checks++; if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush_ifid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", redirect_pc); end
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %b want 0", taken); end
        n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", br_ready); end
        n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL rst_stall0: got %b want 0", stall_id); end
        n_checks++; if (stat_total !== 32'h0 || stat_taken !== 32'h0) begin n_fail++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_total, stat_taken); end
        br_valid = 1'b1;
        #1;
        n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL rst_stall1: got %b want 1", stall_id); end
        br_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step;
    endtask

    task automatic test_directed;
        run_branch(3'd0, 32'h12345678, 32'h12345678, 32'h00400004, 16'h0003);
        n_checks++; if (redirect_pc !== 32'h00400010) begin n_fail++; $display("FAIL beq_target: got %h want 00400010", redirect_pc); end
        run_branch(3'd5, 32'h00000001, 32'h0, 32'h00400004, 16'h0010);
        run_branch(3'd3, 32'h80000000, 32'h0, 32'h00400004, 16'h0010);
        run_branch(3'd4, 32'h00000000, 32'h5, 32'h00400100, 16'hFFF0);
        br_valid = 1'b0;
        step;
    endtask

    task automatic test_wrap;
        run_branch(3'd2, 32'h00000007, 32'h0, 32'h00000000, 16'hFFFF);
        n_checks++; if (redirect_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_target: got %h want fffffffc", redirect_pc); end
        br_valid = 1'b0;
        step;
    endtask

    task automatic test_opnd_stall;
        br_valid = 1'b1; opnd_ready = 1'b0; br_op = 3'd0;
        rs_val = 32'hA5A5A5A5; rt_val = 32'hA5A5A5A5; pc_plus4 = 32'h00001000; imm16 = 16'h0008;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL opnd_stall%0d: got %b want 1", i, stall_id); end
            step;
            n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL opnd_noaccept%0d: got %b want 1", i, br_ready); end
        end
        run_branch(3'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00001000, 16'h0008);
        br_valid = 1'b0;
        step;
    endtask

    task automatic test_flush_eval;
        run_branch(3'd0, 32'h1, 32'h2, 32'h00002000, 16'h0004);
        br_op = 3'd1; rs_val = 32'h1; rt_val = 32'h2; pc_plus4 = 32'h00003000; imm16 = 16'h0020;
        br_valid = 1'b1; opnd_ready = 1'b1;
        step;
        br_valid = 1'b0; flush_in = 1'b1;
        step;
        flush_in = 1'b0;
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL flush_redirect: got %b want 0", redirect); end
        n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got %b want 1", br_ready); end
        n_checks++; if (taken !== m_last) begin n_fail++; $display("FAIL flush_taken: got %b want %b", taken, m_last); end
        n_checks++; if (stat_total !== m_total) begin n_fail++; $display("FAIL flush_stat: got %0d want %0d", stat_total, m_total); end
        step;
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL flush_late: got %b want 0", redirect); end
    endtask

    task automatic test_random;
        logic [31:0] rs, rt;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: rs = 32'h0;
                1: rs = 32'h80000000;
                2: rs = $urandom_range(0, 3) - 1;
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
            run_branch(3'($urandom_range(0, 7)), rs, rt, $urandom, 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                br_valid = 1'b0;
                step;
            end
        end
        br_valid = 1'b0;
        step;
    endtask

    task automatic test_reset_redir;
        br_op = 3'd0; rs_val = 32'h55; rt_val = 32'h55; pc_plus4 = 32'h00004000; imm16 = 16'h0001;
        br_valid = 1'b1; opnd_ready = 1'b1;
        step;
        br_valid = 1'b0;
        step;
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL pre_reset_redirect: got %b want 1", redirect); end
        #2 rst_n = 1'b0;
        #1;
        m_total = 0; m_taken = 0; m_last = 1'b0;
        n_checks++; if (redirect !== 1'b0 || flush_ifid !== 1'b0) begin n_fail++; $display("FAIL async_rst_pulse: got %b%b want 00", redirect, flush_ifid); end
        n_checks++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_idle: got %b want 1", br_ready); end
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL async_rst_taken: got %b want 0", taken); end
        n_checks++; if (stat_total !== 32'h0 || stat_taken !== 32'h0) begin n_fail++; $display("FAIL async_rst_stats: got %0d/%0d want 0/0", stat_total, stat_taken); end
        @(negedge clk) rst_n = 1'b1;
        step;
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL post_reset_redirect: got %b want 0", redirect); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_wrap;
        test_opnd_stall;
        test_flush_eval;
        test_random;
        test_reset_redir;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
